// File: rtl/ucnt_window.sv
// Multi-channel windowed unary bitstream counter: counts stream bits over 2^WIN_LOG2 run cycles,
// then latches per-channel results with a valid pulse. Optional gray_out port: UCNT_GRAY_OUT_EN.
module ucnt_window #(
  parameter int CH       = 4,
  parameter int CW       = 8,
  parameter int WIN_LOG2 = 8,
  parameter int BIPOLAR  = 0,
  parameter int SAT      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic [CH-1:0]      bit_in,
  output logic [CH*CW-1:0]   cnt_live,
  output logic [CH*CW-1:0]   cnt_out,
  output logic [CH-1:0]      ovf,
  output logic               out_valid,
  output logic               busy
`ifdef UCNT_GRAY_OUT_EN
  , output logic [CH*CW-1:0] gray_out
`endif
);

  // state | meaning
  // IDLE  | no window in progress; first run=1 cycle starts one
  // RUN   | window in progress (possibly paused by run=0)
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] HI  = (BIPOLAR != 0) ? {1'b0, {(CW-1){1'b1}}} : {CW{1'b1}};
  localparam logic [CW-1:0] LO  = (BIPOLAR != 0) ? {1'b1, {(CW-1){1'b0}}} : {CW{1'b0}};
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] WONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [CH*CW-1:0]     acc, acc_nxt;
  logic [CH-1:0]        sticky, evt;
  logic [WIN_LOG2-1:0]  wcnt;
  logic                 done;

  assign done     = run && !clr && (wcnt == {WIN_LOG2{1'b1}});
  assign cnt_live = acc;
  assign busy     = (state == RUN);

  // Per-channel step: a limit hit is an overflow event whether we clamp or wrap.
  always_comb begin
    acc_nxt = acc;
    evt     = '0;
    for (int ch = 0; ch < CH; ch++) begin
      if (bit_in[ch]) begin
        if (acc[ch*CW +: CW] == HI) begin
          evt[ch] = 1'b1;
          if (SAT == 0) acc_nxt[ch*CW +: CW] = acc[ch*CW +: CW] + ONE;
        end else begin
          acc_nxt[ch*CW +: CW] = acc[ch*CW +: CW] + ONE;
        end
      end else if (BIPOLAR != 0) begin
        if (acc[ch*CW +: CW] == LO) begin
          evt[ch] = 1'b1;
          if (SAT == 0) acc_nxt[ch*CW +: CW] = acc[ch*CW +: CW] - ONE;
        end else begin
          acc_nxt[ch*CW +: CW] = acc[ch*CW +: CW] - ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr)       state_nxt = IDLE;
    else if (done) state_nxt = IDLE;
    else if (run)  state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sticky    <= '0;
      wcnt      <= '0;
      cnt_out   <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        acc    <= '0;
        sticky <= '0;
        wcnt   <= '0;
      end else if (done) begin
        cnt_out   <= acc_nxt;
        ovf       <= sticky | evt;
        out_valid <= 1'b1;
        acc       <= '0;
        sticky    <= '0;
        wcnt      <= '0;
      end else if (run) begin
        acc    <= acc_nxt;
        sticky <= sticky | evt;
        wcnt   <= wcnt + WONE;
      end
    end
  end

`ifdef UCNT_GRAY_OUT_EN
  always_comb begin
    gray_out = '0;
    for (int ch = 0; ch < CH; ch++)
      gray_out[ch*CW +: CW] = cnt_out[ch*CW +: CW] ^ (cnt_out[ch*CW +: CW] >> 1);
  end
`endif

endmodule

// File: tb/tb_ucnt_window.sv
// Randomized bench for ucnt_window: four configurations (unipolar/bipolar x wrap/saturate)
// share one stimulus and are checked every cycle against an integer-arithmetic reference model.
module tb_ucnt_window;
  localparam int CH  = 4;
  localparam int CW  = 4;
  localparam int WL  = 4;
  localparam int WIN = 1 << WL;
  localparam int NK  = 4;

  logic clk = 1'b0;
  logic rst_n, clr, run;
  logic [CH-1:0] bit_in;
  logic [CH*CW-1:0] cnt_live_a [NK];
  logic [CH*CW-1:0] cnt_out_a  [NK];
  logic [CH-1:0]    ovf_a      [NK];
  logic             out_valid_a[NK];
  logic             busy_a     [NK];
`ifdef UCNT_GRAY_OUT_EN
  logic [CH*CW-1:0] gray_a     [NK];
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    ucnt_window #(.CH(CH), .CW(CW), .WIN_LOG2(WL), .BIPOLAR(k / 2), .SAT(k % 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .bit_in(bit_in),
      .cnt_live(cnt_live_a[k]), .cnt_out(cnt_out_a[k]), .ovf(ovf_a[k]),
      .out_valid(out_valid_a[k]), .busy(busy_a[k])
`ifdef UCNT_GRAY_OUT_EN
      , .gray_out(gray_a[k])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: signed integer accumulators, a window run-cycle count and latched results.
  int               m_acc [NK][CH];
  bit               m_stk [NK][CH];
  logic [CH*CW-1:0] m_out [NK];
  logic [CH-1:0]    m_ovf [NK];
  bit               m_valid, m_busy;
  int               m_runs;

  function automatic logic [CH*CW-1:0] pack_acc(input int k);
    logic [CH*CW-1:0] p;
    int v;
    p = '0;
    for (int ch = 0; ch < CH; ch++) begin
      v = m_acc[k][ch];
      p[ch*CW +: CW] = v[CW-1:0];
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        m_acc[k][ch] = 0;
        m_stk[k][ch] = 0;
      end
      m_out[k] = '0;
      m_ovf[k] = '0;
    end
    m_valid = 0;
    m_busy  = 0;
    m_runs  = 0;
  endtask

  task automatic model_step(input logic r, input logic c, input logic [CH-1:0] b);
    int hi, lo, val;
    bit bip, sat;
    m_valid = 0;
    if (c) begin
      for (int k = 0; k < NK; k++)
        for (int ch = 0; ch < CH; ch++) begin
          m_acc[k][ch] = 0;
          m_stk[k][ch] = 0;
        end
      m_runs = 0;
      m_busy = 0;
    end else if (r) begin
      for (int k = 0; k < NK; k++) begin
        bip = (k / 2) != 0;
        sat = (k % 2) != 0;
        hi  = bip ? (1 << (CW - 1)) - 1 : (1 << CW) - 1;
        lo  = bip ? -(1 << (CW - 1)) : 0;
        for (int ch = 0; ch < CH; ch++) begin
          val = m_acc[k][ch] + (b[ch] ? 1 : (bip ? -1 : 0));
          if (val > hi || val < lo) begin
            m_stk[k][ch] = 1;
            if (sat)           val = (val > hi) ? hi : lo;
            else if (val > hi) val = val - (1 << CW);
            else               val = val + (1 << CW);
          end
          m_acc[k][ch] = val;
        end
      end
      m_runs++;
      if (m_runs == WIN) begin
        for (int k = 0; k < NK; k++) begin
          m_out[k] = pack_acc(k);
          for (int ch = 0; ch < CH; ch++) begin
            m_ovf[k][ch] = m_stk[k][ch];
            m_acc[k][ch] = 0;
            m_stk[k][ch] = 0;
          end
        end
        m_runs  = 0;
        m_valid = 1;
        m_busy  = 0;
      end else begin
        m_busy = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [CH*CW-1:0] g;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("cnt_live[%0d]", k), 64'(cnt_live_a[k]), 64'(pack_acc(k)));
      chk($sformatf("cnt_out[%0d]", k), 64'(cnt_out_a[k]), 64'(m_out[k]));
      chk($sformatf("ovf[%0d]", k), 64'(ovf_a[k]), 64'(m_ovf[k]));
      chk($sformatf("out_valid[%0d]", k), 64'(out_valid_a[k]), 64'(m_valid));
      chk($sformatf("busy[%0d]", k), 64'(busy_a[k]), 64'(m_busy));
`ifdef UCNT_GRAY_OUT_EN
      for (int ch = 0; ch < CH; ch++)
        g[ch*CW +: CW] = m_out[k][ch*CW +: CW] ^ {1'b0, m_out[k][ch*CW+1 +: CW-1]};
      chk($sformatf("gray_out[%0d]", k), 64'(gray_a[k]), 64'(g));
`else
      g = '0;
`endif
    end
  endtask

  // Called at a falling edge: check, then drive the next cycle's inputs.
  task automatic step(input logic r, input logic c, input logic [CH-1:0] b);
    check_all();
    run = r;
    clr = c;
    bit_in = b;
    model_step(r, c, b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    clr = 1'b0;
    bit_in = '0;
    #2;
    model_reset();
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    clr = 1'b0;
    bit_in = '0;
    @(negedge clk);
    do_reset();
    step(0, 0, '0);
    // all ones: saturate vs wrap, channel-distinct pattern on another window
    for (int i = 0; i < WIN; i++) step(1, 0, 4'hF);
    for (int i = 0; i < WIN; i++) step(1, 0, 4'b0101);
    // bipolar balance and all zeros
    for (int i = 0; i < WIN; i++) step(1, 0, i[0] ? 4'h0 : 4'hF);
    for (int i = 0; i < WIN; i++) step(1, 0, 4'h0);
    // pause of 5 cycles mid-window, then a back-to-back window
    for (int i = 0; i < 8; i++) step(1, 0, 4'hF);
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0);
    for (int i = 0; i < 8 + WIN; i++) step(1, 0, 4'hF);
    // clr at wcnt=7, then a full window
    for (int i = 0; i < 7; i++) step(1, 0, 4'hF);
    step(1, 1, 4'hF);
    step(0, 0, 4'h0);
    for (int i = 0; i < WIN; i++) step(1, 0, 4'b0011);
    // clr on the completion cycle suppresses the latch
    for (int i = 0; i < WIN - 1; i++) step(1, 0, 4'hA);
    step(1, 1, 4'hA);
    step(0, 0, 4'h0);
    // reset mid-window
    for (int i = 0; i < 9; i++) step(1, 0, 4'h6);
    do_reset();
    step(0, 0, '0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 85, $urandom_range(199) == 0, 4'($urandom));
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
